// File: rtl/complex_add_pkg.sv
// Shared constants and types for the complex adder: default lane width,
// operand packing offsets, saturation limits and the lane operation type.
package complex_add_pkg;

  // Default width of one real or imaginary component.
  localparam int unsigned DEFAULT_W = 16;

  // Packing of a complex word: {real[2W-1:W], imag[W-1:0]}.
  localparam int unsigned IM_LSB = 0;

  // The real field starts right above the imaginary field.
  function automatic int unsigned re_lsb(input int unsigned w);
    return w;
  endfunction

  // Saturation limits at the default width. Other widths build the same
  // pattern locally: 0111..1 for positive and 1000..0 for negative.
  localparam logic [DEFAULT_W-1:0] SAT_POS_DEFAULT = {1'b0, {(DEFAULT_W-1){1'b1}}};
  localparam logic [DEFAULT_W-1:0] SAT_NEG_DEFAULT = {1'b1, {(DEFAULT_W-1){1'b0}}};

  // Lane operation selected by the sub input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Per-lane overflow flags, packed in the same {real, imag} order as data.
  typedef struct packed {
    logic re;
    logic im;
  } ovf_t;

endpackage : complex_add_pkg

// File: rtl/sat_addsub.sv
// One signed lane: W-bit add or subtract through a W+1-bit sign-extended
// sum, overflow detection on the top two sum bits, optional saturation.
// Purely combinational; the parent registers the result.
module sat_addsub
  import complex_add_pkg::*;
#(
  parameter int unsigned W        = DEFAULT_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] y_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] POS_LIMIT = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_LIMIT = {1'b1, {(W-1){1'b0}}};
  localparam logic [W:0]   ONE       = {{W{1'b0}}, 1'b1};

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] b_opnd;
  logic [W:0] sum;

  // Sign-extend, negate b in the wide domain when subtracting (so the most
  // negative b becomes a representable +2^(W-1)), add, then clamp or wrap.
  always_comb begin
    // NOTE: every signal written here gets a value on every path before any
    // conditional override, which keeps this block free of inferred latches.
    a_ext  = {a_i[W-1], a_i};
    b_ext  = {b_i[W-1], b_i};
    b_opnd = b_ext;
    if (op_i == OP_SUB) begin
      b_opnd = ~b_ext + ONE;
    end
    sum   = a_ext + b_opnd;
    ovf_o = sum[W] ^ sum[W-1];
    y_o   = sum[W-1:0];
    if (SATURATE && ovf_o) begin
      // The extra top bit carries the true sign of the overflowed result.
      y_o = sum[W] ? NEG_LIMIT : POS_LIMIT;
    end
  end

endmodule : sat_addsub

// File: rtl/complex_add.sv
// Registered complex adder/subtractor. Real and imaginary lanes are computed
// independently by two sat_addsub instances; results, overflow flags and the
// valid strobe are registered here, giving a fixed one-cycle latency.
module complex_add
  import complex_add_pkg::*;
#(
  parameter int unsigned W        = DEFAULT_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid_i,
  input  logic           sub_i,
  input  logic [2*W-1:0] a_i,
  input  logic [2*W-1:0] b_i,
  output logic [2*W-1:0] y_o,
  output logic           out_valid_o,
  output logic [1:0]     ovf_o
);

  localparam int unsigned RE_LSB = re_lsb(W);

  op_e        op;
  logic [W-1:0] y_re;
  logic [W-1:0] y_im;
  logic         ovf_re;
  logic         ovf_im;

  logic [2*W-1:0] y_d, y_q;
  ovf_t           ovf_d, ovf_q;
  logic           out_valid_d, out_valid_q;

  assign op = op_e'(sub_i);

  sat_addsub #(
    .W        (W),
    .SATURATE (SATURATE)
  ) u_lane_re (
    .a_i   (a_i[RE_LSB +: W]),
    .b_i   (b_i[RE_LSB +: W]),
    .op_i  (op),
    .y_o   (y_re),
    .ovf_o (ovf_re)
  );

  sat_addsub #(
    .W        (W),
    .SATURATE (SATURATE)
  ) u_lane_im (
    .a_i   (a_i[IM_LSB +: W]),
    .b_i   (b_i[IM_LSB +: W]),
    .op_i  (op),
    .y_o   (y_im),
    .ovf_o (ovf_im)
  );

  // Capture a new result only on a valid beat; otherwise hold Y and OVF.
  always_comb begin
    y_d         = y_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid_i;
    if (in_valid_i) begin
      y_d[RE_LSB +: W] = y_re;
      y_d[IM_LSB +: W] = y_im;
      ovf_d.re         = ovf_re;
      ovf_d.im         = ovf_im;
    end
  end

  // Output registers; reset clears everything, dropping any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      y_q         <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y_o         = y_q;
  assign ovf_o       = ovf_q;
  assign out_valid_o = out_valid_q;

endmodule : complex_add

// File: tb/tb_complex_add.sv
// Directed bench for complex_add: a saturating and a wrapping instance share
// the same stimulus; each test task compares against hand-computed values.
module tb_complex_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;

  logic [31:0] y_sat, y_wrap;
  logic        v_sat, v_wrap;
  logic [1:0]  ovf_sat, ovf_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  complex_add #(.W(16), .SATURATE(1'b1)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .sub_i       (sub),
    .a_i         (a),
    .b_i         (b),
    .y_o         (y_sat),
    .out_valid_o (v_sat),
    .ovf_o       (ovf_sat)
  );

  complex_add #(.W(16), .SATURATE(1'b0)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .sub_i       (sub),
    .a_i         (a),
    .b_i         (b),
    .y_o         (y_wrap),
    .out_valid_o (v_wrap),
    .ovf_o       (ovf_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the falling edge, then return 1 time unit
  // after the following rising edge so outputs can be sampled.
  task automatic apply(input logic v, input logic s, input logic [31:0] av,
                       input logic [31:0] bv);
    @(negedge clk);
    in_valid = v;
    sub      = s;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({y_sat, ovf_sat, v_sat} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_async sat: got y=%h ovf=%b v=%b want 0/00/0", y_sat, ovf_sat, v_sat);
    end
    // Valid beat presented while reset is held must not appear.
    apply(1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111);
    n_cmp++;
    if ({y_sat, ovf_sat, v_sat, y_wrap, ovf_wrap, v_wrap} !== 70'h0) begin
      n_bad++;
      $display("FAIL reset_held: got y=%h v=%b wrap y=%h v=%b want all 0", y_sat, v_sat, y_wrap, v_wrap);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({y_sat, ovf_sat, v_sat} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_release: got y=%h ovf=%b v=%b want 0/00/0", y_sat, ovf_sat, v_sat);
    end
  endtask

  task automatic test_zero();
    apply(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);
    n_cmp++;
    if (y_sat !== 32'h0 || ovf_sat !== 2'b00 || v_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_add: got y=%h ovf=%b v=%b want 00000000/00/1", y_sat, ovf_sat, v_sat);
    end
  endtask

  task automatic test_negative_add();
    apply(1'b1, 1'b0, 32'hFFF6_FFFF, 32'hFFE2_FFFF);
    n_cmp++;
    if (y_sat !== 32'hFFD8_FFFE || ovf_sat !== 2'b00 || v_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL neg_add sat: got y=%h ovf=%b v=%b want ffd8fffe/00/1", y_sat, ovf_sat, v_sat);
    end
    n_cmp++;
    if (y_wrap !== 32'hFFD8_FFFE || ovf_wrap !== 2'b00) begin
      n_bad++;
      $display("FAIL neg_add wrap: got y=%h ovf=%b want ffd8fffe/00", y_wrap, ovf_wrap);
    end
  endtask

  task automatic test_saturation();
    // Real lane overflows positive.
    apply(1'b1, 1'b0, 32'h7FFF_8000, 32'h0001_0000);
    n_cmp++;
    if (y_sat !== 32'h7FFF_8000 || ovf_sat !== 2'b10) begin
      n_bad++;
      $display("FAIL sat_re_pos: got y=%h ovf=%b want 7fff8000/10", y_sat, ovf_sat);
    end
    n_cmp++;
    if (y_wrap !== 32'h8000_8000 || ovf_wrap !== 2'b10) begin
      n_bad++;
      $display("FAIL wrap_re_pos: got y=%h ovf=%b want 80008000/10", y_wrap, ovf_wrap);
    end
    // Imag lane overflows negative.
    apply(1'b1, 1'b0, 32'h7FFF_8000, 32'h0000_FFFF);
    n_cmp++;
    if (y_sat !== 32'h7FFF_8000 || ovf_sat !== 2'b01) begin
      n_bad++;
      $display("FAIL sat_im_neg: got y=%h ovf=%b want 7fff8000/01", y_sat, ovf_sat);
    end
    n_cmp++;
    if (y_wrap !== 32'h7FFF_7FFF || ovf_wrap !== 2'b01) begin
      n_bad++;
      $display("FAIL wrap_im_neg: got y=%h ovf=%b want 7fff7fff/01", y_wrap, ovf_wrap);
    end
    // Both lanes at most negative: -65536 clamps in both.
    apply(1'b1, 1'b0, 32'h8000_8000, 32'h8000_8000);
    n_cmp++;
    if (y_sat !== 32'h8000_8000 || ovf_sat !== 2'b11) begin
      n_bad++;
      $display("FAIL sat_both_neg: got y=%h ovf=%b want 80008000/11", y_sat, ovf_sat);
    end
    n_cmp++;
    if (y_wrap !== 32'h0000_0000 || ovf_wrap !== 2'b11) begin
      n_bad++;
      $display("FAIL wrap_both_neg: got y=%h ovf=%b want 00000000/11", y_wrap, ovf_wrap);
    end
  endtask

  task automatic test_sub();
    apply(1'b1, 1'b1, 32'h0005_0003, 32'h0007_0001);
    n_cmp++;
    if (y_sat !== 32'hFFFE_0002 || ovf_sat !== 2'b00 || v_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_basic: got y=%h ovf=%b v=%b want fffe0002/00/1", y_sat, ovf_sat, v_sat);
    end
    // Negating the most negative value must overflow to +32767 when saturating.
    apply(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000);
    n_cmp++;
    if (y_sat !== 32'h7FFF_0000 || ovf_sat !== 2'b10) begin
      n_bad++;
      $display("FAIL sub_min_sat: got y=%h ovf=%b want 7fff0000/10", y_sat, ovf_sat);
    end
    n_cmp++;
    if (y_wrap !== 32'h8000_0000 || ovf_wrap !== 2'b10) begin
      n_bad++;
      $display("FAIL sub_min_wrap: got y=%h ovf=%b want 80000000/10", y_wrap, ovf_wrap);
    end
    // Imag lane: 32767 - (-1) overflows positive.
    apply(1'b1, 1'b1, 32'h0000_7FFF, 32'h0000_FFFF);
    n_cmp++;
    if (y_sat !== 32'h0000_7FFF || ovf_sat !== 2'b01) begin
      n_bad++;
      $display("FAIL sub_im_sat: got y=%h ovf=%b want 00007fff/01", y_sat, ovf_sat);
    end
    n_cmp++;
    if (y_wrap !== 32'h0000_8000 || ovf_wrap !== 2'b01) begin
      n_bad++;
      $display("FAIL sub_im_wrap: got y=%h ovf=%b want 00008000/01", y_wrap, ovf_wrap);
    end
  endtask

  task automatic test_gap_stream();
    logic        tv[6]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ta[6]   = '{32'h0001_0001, 32'h7FFF_0000, 32'h1111_1111,
                             32'h0000_0005, 32'hFFFF_0000, 32'h2222_2222};
    logic [31:0] tb_[6]  = '{32'h0001_0001, 32'h0001_0000, 32'h1111_1111,
                             32'h0000_0005, 32'hFFFF_0000, 32'h0101_0101};
    logic [31:0] ey[6]   = '{32'h0002_0002, 32'h7FFF_0000, 32'h7FFF_0000,
                             32'h0000_000A, 32'hFFFE_0000, 32'hFFFE_0000};
    logic [31:0] eyw[6]  = '{32'h0002_0002, 32'h8000_0000, 32'h8000_0000,
                             32'h0000_000A, 32'hFFFE_0000, 32'hFFFE_0000};
    logic [1:0]  eo[6]   = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      apply(tv[i], 1'b0, ta[i], tb_[i]);
      n_cmp++;
      if (v_sat !== tv[i] || y_sat !== ey[i] || ovf_sat !== eo[i]) begin
        n_bad++;
        $display("FAIL stream[%0d] sat: got v=%b y=%h ovf=%b want %b/%h/%b",
                 i, v_sat, y_sat, ovf_sat, tv[i], ey[i], eo[i]);
      end
      n_cmp++;
      if (v_wrap !== tv[i] || y_wrap !== eyw[i] || ovf_wrap !== eo[i]) begin
        n_bad++;
        $display("FAIL stream[%0d] wrap: got v=%b y=%h ovf=%b want %b/%h/%b",
                 i, v_wrap, y_wrap, ovf_wrap, tv[i], eyw[i], eo[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b1, 1'b0, 32'h0005_0003, 32'h0001_0001);
    n_cmp++;
    if (y_sat !== 32'h0006_0004 || v_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: got y=%h v=%b want 00060004/1", y_sat, v_sat);
    end
    // Assert reset between edges; outputs must clear without waiting for clk.
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({y_sat, ovf_sat, v_sat, y_wrap, ovf_wrap, v_wrap} !== 70'h0) begin
      n_bad++;
      $display("FAIL mid_async_clear: got y=%h v=%b wrap y=%h v=%b want all 0",
               y_sat, v_sat, y_wrap, v_wrap);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({y_sat, ovf_sat, v_sat} !== 35'h0) begin
      n_bad++;
      $display("FAIL mid_after_release: got y=%h ovf=%b v=%b want 0/00/0", y_sat, ovf_sat, v_sat);
    end
    apply(1'b0, 1'b0, 32'h0F0F_0F0F, 32'h0101_0101);
    n_cmp++;
    if ({y_sat, ovf_sat, v_sat} !== 35'h0) begin
      n_bad++;
      $display("FAIL mid_idle: got y=%h ovf=%b v=%b want 0/00/0", y_sat, ovf_sat, v_sat);
    end
    apply(1'b1, 1'b0, 32'h0002_0002, 32'h0001_0001);
    n_cmp++;
    if (y_sat !== 32'h0003_0003 || ovf_sat !== 2'b00 || v_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_first_beat: got y=%h ovf=%b v=%b want 00030003/00/1", y_sat, ovf_sat, v_sat);
    end
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (v_sat !== 1'b0 || y_sat !== 32'h0003_0003) begin
      n_bad++;
      $display("FAIL mid_tail: got y=%h v=%b want 00030003/0", y_sat, v_sat);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_negative_add();
    test_saturation();
    test_sub();
    test_gap_stream();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_complex_add
